// File: rtl/sargantana_icache_checker_pipe.sv
// sargantana_icache_checker_pipe
// Pipelined icache tag checker. Compares the physical tag against every way,
// qualifies with the way valid bits, picks the lowest-index hit way and the
// requested fetch chunk of that way's line, and registers the result behind a
// valid/ready handshake. Flags more than one hitting way as an error.
// Optional build macro: ICACHE_CHECKER_PERF_EN adds saturating hit/miss/multi-hit
// counters with a synchronous clear input.
module sargantana_icache_checker_pipe #(
    parameter int N_WAY       = 4,
    parameter int TAG_W       = 20,
    parameter int LINE_W      = 512,
    parameter int FETCH_W     = 128,
    parameter int WAY_IDX_W   = $clog2(N_WAY),
    parameter int CHUNK_IDX_W = $clog2(LINE_W / FETCH_W)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
`ifdef ICACHE_CHECKER_PERF_EN
    input  logic                      perf_clr_i,
    output logic [31:0]               perf_hit_cnt_o,
    output logic [31:0]               perf_miss_cnt_o,
    output logic [31:0]               perf_multi_hit_cnt_o,
`endif
    input  logic                      flush_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [TAG_W-1:0]          req_tag_i,
    input  logic [CHUNK_IDX_W-1:0]    req_chunk_idx_i,
    input  logic [N_WAY-1:0]          way_valid_i,
    input  logic [N_WAY*TAG_W-1:0]    read_tags_i,
    input  logic [N_WAY*LINE_W-1:0]   data_rd_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_hit_o,
    output logic [N_WAY-1:0]          rsp_way_hit_o,
    output logic [WAY_IDX_W-1:0]      rsp_way_idx_o,
    output logic [FETCH_W-1:0]        rsp_data_o,
    output logic                      rsp_multi_hit_o
);

    localparam int N_CHUNK = LINE_W / FETCH_W;

    logic [N_WAY-1:0]     hit;
    logic                 any_hit;
    logic                 multi_hit;
    logic [WAY_IDX_W-1:0] way_idx;
    logic [LINE_W-1:0]    line_sel;
    logic [FETCH_W-1:0]   chunk_sel;
    logic                 accept;
    int                   hit_cnt;

    // Tag compare, lowest-index priority select, popcount and chunk mux.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no
        // latch is inferred; blocking '=' is correct here because the loop
        // accumulates values within one evaluation.
        hit       = '0;
        hit_cnt   = 0;
        way_idx   = '0;
        line_sel  = '0;
        chunk_sel = '0;
        for (int i = 0; i < N_WAY; i++) begin
            hit[i] = (read_tags_i[i*TAG_W +: TAG_W] == req_tag_i) & way_valid_i[i];
            if (hit[i]) hit_cnt = hit_cnt + 1;
        end
        // Walk downward so the lowest hitting index is written last.
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (hit[i]) begin
                way_idx  = WAY_IDX_W'(i);
                line_sel = data_rd_i[i*LINE_W +: LINE_W];
            end
        end
        for (int j = 0; j < N_CHUNK; j++) begin
            if (req_chunk_idx_i == CHUNK_IDX_W'(j)) chunk_sel = line_sel[j*FETCH_W +: FETCH_W];
        end
    end

    assign any_hit     = |hit;
    assign multi_hit   = (hit_cnt >= 2);
    assign req_ready_o = !rsp_valid_o | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;

    // Response register: valid follows the handshake, payload loads only on accept.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            rsp_valid_o     <= 1'b0;
            rsp_hit_o       <= 1'b0;
            rsp_way_hit_o   <= '0;
            rsp_way_idx_o   <= '0;
            rsp_data_o      <= '0;
            rsp_multi_hit_o <= 1'b0;
        end else begin
            if (flush_i)           rsp_valid_o <= 1'b0;
            else if (accept)       rsp_valid_o <= 1'b1;
            else if (rsp_ready_i)  rsp_valid_o <= 1'b0;

            if (accept) begin
                rsp_hit_o       <= any_hit;
                rsp_way_hit_o   <= hit;
                rsp_way_idx_o   <= way_idx;
                rsp_data_o      <= chunk_sel;
                rsp_multi_hit_o <= multi_hit;
            end
        end
    end

`ifdef ICACHE_CHECKER_PERF_EN
    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            perf_hit_cnt_o       <= '0;
            perf_miss_cnt_o      <= '0;
            perf_multi_hit_cnt_o <= '0;
        end else if (accept) begin
            if (any_hit && perf_hit_cnt_o != 32'hFFFF_FFFF)
                perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
            if (!any_hit && perf_miss_cnt_o != 32'hFFFF_FFFF)
                perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
            if (multi_hit && perf_multi_hit_cnt_o != 32'hFFFF_FFFF)
                perf_multi_hit_cnt_o <= perf_multi_hit_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// Testbench for sargantana_icache_checker_pipe (default parameters).
// Expected responses are computed from the driven stimulus, pushed on accept
// and popped when the response handshake completes.
module tb_sargantana_icache_checker_pipe;

    localparam int N_WAY       = 4;
    localparam int TAG_W       = 20;
    localparam int LINE_W      = 512;
    localparam int FETCH_W     = 128;
    localparam int WAY_IDX_W   = $clog2(N_WAY);
    localparam int CHUNK_IDX_W = $clog2(LINE_W / FETCH_W);

    typedef struct {
        logic                 hit;
        logic [N_WAY-1:0]     way_hit;
        logic [WAY_IDX_W-1:0] way_idx;
        logic [FETCH_W-1:0]   data;
        logic                 multi;
    } exp_t;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [TAG_W-1:0]        req_tag_i;
    logic [CHUNK_IDX_W-1:0]  req_chunk_idx_i;
    logic [N_WAY-1:0]        way_valid_i;
    logic [N_WAY*TAG_W-1:0]  read_tags_i;
    logic [N_WAY*LINE_W-1:0] data_rd_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic                    rsp_hit_o;
    logic [N_WAY-1:0]        rsp_way_hit_o;
    logic [WAY_IDX_W-1:0]    rsp_way_idx_o;
    logic [FETCH_W-1:0]      rsp_data_o;
    logic                    rsp_multi_hit_o;
`ifdef ICACHE_CHECKER_PERF_EN
    logic                    perf_clr_i;
    logic [31:0]             perf_hit_cnt_o;
    logic [31:0]             perf_miss_cnt_o;
    logic [31:0]             perf_multi_hit_cnt_o;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    sargantana_icache_checker_pipe #(
        .N_WAY  (N_WAY),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W),
        .FETCH_W(FETCH_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
`ifdef ICACHE_CHECKER_PERF_EN
        .perf_clr_i          (perf_clr_i),
        .perf_hit_cnt_o      (perf_hit_cnt_o),
        .perf_miss_cnt_o     (perf_miss_cnt_o),
        .perf_multi_hit_cnt_o(perf_multi_hit_cnt_o),
`endif
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_tag_i      (req_tag_i),
        .req_chunk_idx_i(req_chunk_idx_i),
        .way_valid_i    (way_valid_i),
        .read_tags_i    (read_tags_i),
        .data_rd_i      (data_rd_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_way_hit_o  (rsp_way_hit_o),
        .rsp_way_idx_o  (rsp_way_idx_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_multi_hit_o(rsp_multi_hit_o)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from the currently driven lookup inputs.
    function automatic exp_t model();
        exp_t e;
        bit   found = 0;
        e.way_hit = '0;
        e.way_idx = '0;
        e.data    = '0;
        for (int i = 0; i < N_WAY; i++)
            e.way_hit[i] = (read_tags_i[i*TAG_W +: TAG_W] == req_tag_i) && way_valid_i[i];
        for (int i = 0; i < N_WAY; i++) begin
            if (e.way_hit[i] && !found) begin
                found     = 1;
                e.way_idx = WAY_IDX_W'(i);
                e.data    = data_rd_i[i*LINE_W + int'(req_chunk_idx_i)*FETCH_W +: FETCH_W];
            end
        end
        e.hit   = found;
        e.multi = ($countones(e.way_hit) > 1);
        return e;
    endfunction

    // Scoreboard monitor, sampled mid-cycle: pop on completed/flushed response,
    // push on an accept that is not flushed.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rsp_valid_o && (rsp_ready_i || flush_i)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (rsp_ready_i) begin
                        check("rsp_hit", rsp_hit_o, e.hit);
                        check("rsp_way_hit", rsp_way_hit_o, e.way_hit);
                        check("rsp_way_idx", rsp_way_idx_o, e.way_idx);
                        check("rsp_data", rsp_data_o, e.data);
                        check("rsp_multi_hit", rsp_multi_hit_o, e.multi);
                    end
                end
            end
            if (req_valid_i && req_ready_o && !flush_i) sb_q.push_back(model());
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a lookup: ways in match_mask carry the request tag, others differ.
    task automatic setup(input logic [TAG_W-1:0] tag, input logic [N_WAY-1:0] match_mask,
                         input logic [N_WAY-1:0] valid, input logic [CHUNK_IDX_W-1:0] chunk);
        req_tag_i       = tag;
        req_chunk_idx_i = chunk;
        way_valid_i     = valid;
        for (int i = 0; i < N_WAY; i++)
            read_tags_i[i*TAG_W +: TAG_W] = match_mask[i] ? tag : tag ^ TAG_W'(i + 1);
        for (int k = 0; k < N_WAY * LINE_W / 32; k++)
            data_rd_i[k*32 +: 32] = $urandom;
    endtask

    exp_t exp_a;

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
`ifdef ICACHE_CHECKER_PERF_EN
        perf_clr_i  = 1'b0;
`endif
        setup(20'h0, 4'b0000, 4'b0000, 2'd0);
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // Reset state.
        check("rst_valid", rsp_valid_o, 0);
        check("rst_hit", rsp_hit_o, 0);
        check("rst_way_hit", rsp_way_hit_o, 0);
        check("rst_way_idx", rsp_way_idx_o, 0);
        check("rst_data", rsp_data_o, 0);
        check("rst_multi", rsp_multi_hit_o, 0);
        check("rst_ready", req_ready_o, 1);

        // Single hit in way 2, last chunk.
        setup(20'h12345, 4'b0100, 4'b1111, 2'd3);
        req_valid_i = 1'b1;
        tick();
        check("hit_valid", rsp_valid_o, 1);
        check("hit_data_way2_top", rsp_data_o, data_rd_i[2*LINE_W + 384 +: FETCH_W]);

        // Tag matches an invalid way -> miss.
        setup(20'h0ABCD, 4'b0010, 4'b1101, 2'd1);
        tick();
        // Two valid hits -> lowest index, multi-hit flag.
        setup(20'h55AA5, 4'b1010, 4'b1111, 2'd2);
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();

        // Random traffic with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            setup(TAG_W'($urandom), N_WAY'($urandom), N_WAY'($urandom), CHUNK_IDX_W'($urandom));
            req_valid_i = ($urandom_range(3) != 0);
            rsp_ready_i = ($urandom_range(3) != 0);
            tick();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        tick();

        // Back-pressure hold: payload stable, not ready, then same-cycle accept.
        setup(20'h0F0F0, 4'b0001, 4'b1111, 2'd0);
        exp_a       = model();
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b0;
        tick();
        check("bp_valid", rsp_valid_o, 1);
        setup(20'h33333, 4'b1000, 4'b1111, 2'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("bp_ready_low", req_ready_o, 0);
            check("bp_valid_hold", rsp_valid_o, 1);
            check("bp_data_hold", rsp_data_o, exp_a.data);
            check("bp_way_hit_hold", rsp_way_hit_o, exp_a.way_hit);
        end
        rsp_ready_i = 1'b1;
        #1;
        check("bp_ready_high", req_ready_o, 1);
        tick();
        check("bp_next_valid", rsp_valid_o, 1);
        req_valid_i = 1'b0;
        tick();
        check("bp_drained", rsp_valid_o, 0);

        // Flush together with accept.
        setup(20'h77777, 4'b0100, 4'b1111, 2'd2);
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        check("flush_ready", req_ready_o, 1);
        tick();
        check("flush_accept_valid", rsp_valid_o, 0);

        // Flush of a held response.
        flush_i     = 1'b0;
        rsp_ready_i = 1'b0;
        tick();
        check("flush_pend_valid", rsp_valid_o, 1);
        req_valid_i = 1'b0;
        flush_i     = 1'b1;
        tick();
        check("flush_pend_dropped", rsp_valid_o, 0);
        flush_i     = 1'b0;
        rsp_ready_i = 1'b1;
        tick();

`ifdef ICACHE_CHECKER_PERF_EN
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        check("perf_clr_hit", perf_hit_cnt_o, 0);
        req_valid_i = 1'b1;
        for (int n = 0; n < 10; n++) begin
            setup(TAG_W'($urandom), N_WAY'(1 << (n % N_WAY)), 4'b1111, CHUNK_IDX_W'(n));
            tick();
        end
        for (int n = 0; n < 5; n++) begin
            setup(TAG_W'($urandom), 4'b0000, 4'b1111, CHUNK_IDX_W'(n));
            tick();
        end
        req_valid_i = 1'b0;
        tick();
        check("perf_hit_10", perf_hit_cnt_o, 10);
        check("perf_miss_5", perf_miss_cnt_o, 5);
        check("perf_multi_0", perf_multi_hit_cnt_o, 0);
        setup(20'h11111, 4'b0011, 4'b1111, 2'd0);
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        check("perf_hit_11", perf_hit_cnt_o, 11);
        check("perf_multi_1", perf_multi_hit_cnt_o, 1);
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        check("perf_clr_hit2", perf_hit_cnt_o, 0);
        check("perf_clr_miss", perf_miss_cnt_o, 0);
        check("perf_clr_multi", perf_multi_hit_cnt_o, 0);
`endif

        // Drain with a bounded wait.
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) tick();
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
